// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - segment pattern constants, frame FSM state type, strobe helper
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0011000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] BLANK_CODE = 4'hF;

  typedef enum logic [2:0] {
    SYNC,
    DIG0,
    DIG1,
    DIG2,
    DIG3
  } state_t;

  // Index of the single low strobe; only meaningful when exactly one bit is low.
  function automatic logic [1:0] strobe_index(input logic [3:0] an);
    case (an)
      4'b1101: return 2'd1;
      4'b1011: return 2'd2;
      4'b0111: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// rtl/seg7_to_bcd.sv - active-low 7-segment pattern to BCD code lookup
module seg7_to_bcd
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] code,
  output logic       valid
);

  always_comb begin
    code  = BLANK_CODE;
    valid = 1'b1;
    case (seg)
      SEG_0:     code = 4'd0;
      SEG_1:     code = 4'd1;
      SEG_2:     code = 4'd2;
      SEG_3:     code = 4'd3;
      SEG_4:     code = 4'd4;
      SEG_5:     code = 4'd5;
      SEG_6:     code = 4'd6;
      SEG_7:     code = 4'd7;
      SEG_8:     code = 4'd8;
      SEG_9:     code = 4'd9;
      SEG_BLANK: code = BLANK_CODE;
      default:   valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_reader.sv
// rtl/seg7_scan_reader.sv - debounced capture of a multiplexed 4-digit display into BCD frames
module seg7_scan_reader
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int NUM_DIGITS    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              an,
  input  logic [6:0]              seg,
  input  logic                    dp,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   dp_flags,
  output logic                    frame_valid,
  output logic                    pat_err,
  output logic                    seq_err,
  output logic [1:0]              err_digit
);

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

  logic [3:0] an_q;
  logic [6:0] seg_q;
  logic [7:0] cnt_q, cnt_d;
  logic       done_q, done_d;
  logic       an_chg;
  logic       capture;
  logic       multi_low;
  logic [1:0] strobe_idx;
  logic [1:0] exp_idx;
  logic [3:0] code;
  logic       code_valid;

  state_t                    state_q;
  logic [4*NUM_DIGITS-5:0]   part_q;
  logic [NUM_DIGITS-2:0]     part_dp_q;
  logic [4*NUM_DIGITS-1:0]   digits_q;
  logic [NUM_DIGITS-1:0]     dp_flags_q;
  logic                      frame_valid_q;
  logic                      pat_err_q;
  logic                      seq_err_q;
  logic [1:0]                err_digit_q;

  seg7_to_bcd u_decode (
    .seg   (seg),
    .code  (code),
    .valid (code_valid)
  );

  // done_q blocks a second capture until the strobe itself moves on.
  always_comb begin
    an_chg = (an != an_q);
    if (an_chg || (seg != seg_q)) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
    capture = (cnt_d == CNT_MAX) && !done_q && (an != 4'hF);
    done_d  = an_chg ? 1'b0 : (done_q || capture);
  end

  assign multi_low  = ($countones(~an) > 1);
  assign strobe_idx = strobe_index(an);

  always_comb begin
    case (state_q)
      DIG1:    exp_idx = 2'd1;
      DIG2:    exp_idx = 2'd2;
      DIG3:    exp_idx = 2'd3;
      default: exp_idx = 2'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_q   <= 4'hF;
      seg_q  <= SEG_BLANK;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      an_q   <= an;
      seg_q  <= seg;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= SYNC;
      part_q        <= '0;
      part_dp_q     <= '0;
      digits_q      <= '1;
      dp_flags_q    <= '0;
      frame_valid_q <= 1'b0;
      pat_err_q     <= 1'b0;
      seq_err_q     <= 1'b0;
      err_digit_q   <= 2'd0;
    end else begin
      frame_valid_q <= 1'b0;
      pat_err_q     <= 1'b0;
      seq_err_q     <= 1'b0;
      if (capture) begin
        if (multi_low) begin
          seq_err_q   <= 1'b1;
          err_digit_q <= exp_idx;
          state_q     <= SYNC;
        end else if (state_q == SYNC || state_q == DIG0) begin
          if (strobe_idx == 2'd0) begin
            if (code_valid) begin
              part_q[3:0]  <= code;
              part_dp_q[0] <= dp;
              state_q      <= DIG1;
            end else begin
              pat_err_q   <= 1'b1;
              err_digit_q <= 2'd0;
            end
          end
        end else if (strobe_idx == exp_idx) begin
          if (!code_valid) begin
            pat_err_q   <= 1'b1;
            err_digit_q <= exp_idx;
            state_q     <= SYNC;
          end else begin
            case (exp_idx)
              2'd1: begin
                part_q[7:4]  <= code;
                part_dp_q[1] <= dp;
                state_q      <= DIG2;
              end
              2'd2: begin
                part_q[11:8] <= code;
                part_dp_q[2] <= dp;
                state_q      <= DIG3;
              end
              default: begin
                digits_q      <= {code, part_q};
                dp_flags_q    <= {dp, part_dp_q};
                frame_valid_q <= 1'b1;
                state_q       <= SYNC;
              end
            endcase
          end
        end else begin
          // Out-of-order strobe; a clean digit-0 capture doubles as a frame restart.
          seq_err_q   <= 1'b1;
          err_digit_q <= exp_idx;
          if (strobe_idx == 2'd0 && code_valid) begin
            part_q[3:0]  <= code;
            part_dp_q[0] <= dp;
            state_q      <= DIG1;
          end else begin
            state_q <= SYNC;
          end
        end
      end
    end
  end

  assign digits      = digits_q;
  assign dp_flags    = dp_flags_q;
  assign frame_valid = frame_valid_q;
  assign pat_err     = pat_err_q;
  assign seq_err     = seq_err_q;
  assign err_digit   = err_digit_q;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// tb/tb_seg7_scan_reader.sv - directed and randomized scans against a frame-level reference model
module tb_seg7_scan_reader;

  localparam int STABLE = 4;

  logic        clk;
  logic        rst;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [15:0] digits;
  logic [3:0]  dp_flags;
  logic        frame_valid;
  logic        pat_err;
  logic        seq_err;
  logic [1:0]  err_digit;

  seg7_scan_reader #(.STABLE_CYCLES(STABLE), .NUM_DIGITS(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .digits      (digits),
    .dp_flags    (dp_flags),
    .frame_valid (frame_valid),
    .pat_err     (pat_err),
    .seq_err     (seq_err),
    .err_digit   (err_digit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] pat_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000};

  int n_cmp, n_err;
  int fv_cnt, pe_cnt, se_cnt;

  // Reference model: run length of identical samples, current frame slot, published frame.
  logic [3:0]  m_an;
  logic [6:0]  m_seg;
  int          m_run;
  bit          m_took;
  int          m_pos;
  int          fr [4];
  bit          fdp [4];
  logic [15:0] m_digits;
  logic [3:0]  m_dpf;
  bit          m_fv, m_pe, m_se;
  int          m_ed;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int decode(input logic [6:0] s);
    if (s == 7'h7F) return 15;
    for (int i = 0; i < 10; i++) if (pat_tab[i] == s) return i;
    return -1;
  endfunction

  function automatic logic [3:0] sel(input int k);
    logic [3:0] one;
    one = 4'b0001 << k;
    return ~one;
  endfunction

  task automatic model_reset();
    m_an = 4'hF; m_seg = 7'h7F; m_run = 1; m_took = 0; m_pos = 0;
    m_digits = 16'hFFFF; m_dpf = 4'h0; m_fv = 0; m_pe = 0; m_se = 0; m_ed = 0;
  endtask

  task automatic model_step(input logic [3:0] a, input logic [6:0] s, input logic d);
    int k, v;
    m_fv = 0; m_pe = 0; m_se = 0;
    if (a == m_an && s == m_seg) m_run++;
    else begin
      if (a != m_an) m_took = 0;
      m_run = 1;
    end
    m_an = a; m_seg = s;
    if (m_run == STABLE && !m_took && a != 4'hF) begin
      m_took = 1;
      k = -1;
      for (int i = 0; i < 4; i++) if (a == sel(i)) k = i;
      v = decode(s);
      if (k < 0) begin
        m_se = 1; m_ed = m_pos; m_pos = 0;
      end else if (m_pos == 0) begin
        if (k == 0) begin
          if (v >= 0) begin fr[0] = v; fdp[0] = d; m_pos = 1; end
          else begin m_pe = 1; m_ed = 0; end
        end
      end else if (k == m_pos) begin
        if (v < 0) begin
          m_pe = 1; m_ed = m_pos; m_pos = 0;
        end else begin
          fr[m_pos] = v; fdp[m_pos] = d;
          if (m_pos == 3) begin
            m_digits = {4'(fr[3]), 4'(fr[2]), 4'(fr[1]), 4'(fr[0])};
            m_dpf = {fdp[3], fdp[2], fdp[1], fdp[0]};
            m_fv = 1; m_pos = 0;
          end else m_pos++;
        end
      end else begin
        m_se = 1; m_ed = m_pos;
        if (k == 0 && v >= 0) begin fr[0] = v; fdp[0] = d; m_pos = 1; end
        else m_pos = 0;
      end
    end
  endtask

  task automatic step(input logic [3:0] a, input logic [6:0] s, input logic d);
    an = a; seg = s; dp = d;
    @(posedge clk);
    model_step(a, s, d);
    #1;
    check("digits", 32'(digits), 32'(m_digits));
    check("dp_flags", 32'(dp_flags), 32'(m_dpf));
    check("frame_valid", 32'(frame_valid), 32'(m_fv));
    check("pat_err", 32'(pat_err), 32'(m_pe));
    check("seq_err", 32'(seq_err), 32'(m_se));
    check("err_digit", 32'(err_digit), 32'(m_ed));
    if (frame_valid) fv_cnt++;
    if (pat_err) pe_cnt++;
    if (seq_err) se_cnt++;
  endtask

  task automatic strobe(input int k, input logic [6:0] s, input logic d, input int hold, input int gap);
    for (int c = 0; c < hold; c++) step(sel(k), s, d);
    for (int c = 0; c < gap; c++) step(4'hF, 7'h7F, 1'b0);
  endtask

  task automatic clear_counts();
    fv_cnt = 0; pe_cnt = 0; se_cnt = 0;
  endtask

  task automatic mid_reset();
    rst = 1'b1;
    #2;
    check("arst_digits", 32'(digits), 32'h0000FFFF);
    check("arst_dp_flags", 32'(dp_flags), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    clear_counts();
    model_reset();
    rst = 1'b1; an = 4'hF; seg = 7'h7F; dp = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_digits", 32'(digits), 32'h0000FFFF);
    check("rst_dp_flags", 32'(dp_flags), 32'h0);
    check("rst_frame_valid", 32'(frame_valid), 32'h0);
    check("rst_pat_err", 32'(pat_err), 32'h0);
    check("rst_seq_err", 32'(seq_err), 32'h0);
    check("rst_err_digit", 32'(err_digit), 32'h0);

    // Basic frame 1,2,3,4
    clear_counts();
    strobe(0, pat_tab[1], 1'b0, 6, 2);
    strobe(1, pat_tab[2], 1'b0, 6, 2);
    strobe(2, pat_tab[3], 1'b0, 6, 2);
    strobe(3, pat_tab[4], 1'b0, 6, 2);
    check("frame1_count", 32'(fv_cnt), 32'd1);
    check("frame1_digits", 32'(digits), 32'h4321);

    // Blank digit 1 with decimal point
    clear_counts();
    strobe(0, pat_tab[1], 1'b0, 6, 2);
    strobe(1, 7'h7F, 1'b1, 6, 2);
    strobe(2, pat_tab[2], 1'b0, 6, 2);
    strobe(3, pat_tab[3], 1'b0, 6, 2);
    check("blank_digits", 32'(digits), 32'h32F1);
    check("blank_dp_flags", 32'(dp_flags), 32'b0010);
    check("blank_no_pat_err", 32'(pe_cnt), 32'd0);

    // Invalid pattern on digit 2
    clear_counts();
    strobe(0, pat_tab[5], 1'b0, 6, 2);
    strobe(1, pat_tab[6], 1'b0, 6, 2);
    strobe(2, 7'b0101010, 1'b0, 6, 2);
    strobe(3, pat_tab[7], 1'b0, 6, 2);
    check("badpat_count", 32'(pe_cnt), 32'd1);
    check("badpat_err_digit", 32'(err_digit), 32'd2);
    check("badpat_no_frame", 32'(fv_cnt), 32'd0);
    check("badpat_digits", 32'(digits), 32'h32F1);

    // Strobe order 0,2 then a clean frame
    clear_counts();
    strobe(0, pat_tab[1], 1'b0, 6, 2);
    strobe(2, pat_tab[2], 1'b0, 6, 2);
    check("order_seq_err", 32'(se_cnt), 32'd1);
    check("order_err_digit", 32'(err_digit), 32'd1);
    strobe(0, pat_tab[5], 1'b0, 6, 1);
    strobe(1, pat_tab[6], 1'b1, 6, 1);
    strobe(2, pat_tab[7], 1'b0, 6, 1);
    strobe(3, pat_tab[8], 1'b0, 6, 1);
    check("order_recover_digits", 32'(digits), 32'h8765);
    check("order_recover_count", 32'(fv_cnt), 32'd1);

    // Segment glitch every 3 cycles never stabilises
    clear_counts();
    for (int c = 0; c < 30; c++) step(4'b1110, ((c / 3) % 2) ? pat_tab[3] : pat_tab[8], 1'b0);
    step(4'hF, 7'h7F, 1'b0);
    check("glitch_no_frame", 32'(fv_cnt), 32'd0);
    check("glitch_no_pat_err", 32'(pe_cnt), 32'd0);
    check("glitch_no_seq_err", 32'(se_cnt), 32'd0);

    // Reset during DIG2, then a full frame
    clear_counts();
    strobe(0, pat_tab[3], 1'b0, 6, 2);
    strobe(1, pat_tab[4], 1'b0, 6, 2);
    step(4'b1011, pat_tab[5], 1'b0);
    step(4'b1011, pat_tab[5], 1'b0);
    mid_reset();
    strobe(2, pat_tab[5], 1'b0, 6, 2);
    strobe(3, pat_tab[6], 1'b0, 6, 2);
    check("postrst_no_frame", 32'(fv_cnt), 32'd0);
    strobe(0, pat_tab[9], 1'b0, 6, 2);
    strobe(1, pat_tab[0], 1'b0, 6, 2);
    strobe(2, pat_tab[1], 1'b0, 6, 2);
    strobe(3, pat_tab[2], 1'b0, 6, 2);
    check("postrst_digits", 32'(digits), 32'h2109);
    check("postrst_count", 32'(fv_cnt), 32'd1);

    // Randomized scanning with occasional disorder, bad patterns, glitches and resets
    for (int n = 0; n < 400; n++) begin
      logic [3:0] a;
      logic [6:0] s;
      logic       d;
      int hold, gap, glitch_at, r;
      r = $urandom_range(0, 99);
      if (r < 75) a = sel(m_pos);
      else if (r < 90) a = sel($urandom_range(0, 3));
      else a = 4'($urandom_range(0, 15));
      r = $urandom_range(0, 99);
      if (r < 80) s = pat_tab[$urandom_range(0, 9)];
      else if (r < 88) s = 7'h7F;
      else s = 7'($urandom_range(0, 127));
      d = 1'($urandom_range(0, 1));
      hold = $urandom_range(1, 8);
      gap = $urandom_range(0, 3);
      glitch_at = ($urandom_range(0, 9) == 0) ? $urandom_range(0, hold - 1) : -1;
      for (int c = 0; c < hold; c++) step(a, (c == glitch_at) ? (s ^ 7'h08) : s, d);
      for (int c = 0; c < gap; c++) step(4'hF, 7'h7F, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 99) == 0) mid_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seg7_scan_reader.md
SEG7_SCAN_READER -- requirements
Module: seg7_scan_reader

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4: consecutive identical cycles of an/seg required before a digit is captured (legal range 2..255).
REQ-002 SHALL have parameter NUM_DIGITS, default 4, fixed at 4; other values are not supported.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 an  input  4  digit strobes, active-low, one-hot-low; an[k]=0 selects digit k.
REQ-006 seg  input  7  segment lines, active-low; bit0=a … bit6=g.
REQ-007 dp  input  1  decimal-point line, active-high.
REQ-008 digits  output  16  captured BCD frame; digits[4k+3:4k] holds digit k.
REQ-009 dp_flags  output  4  captured dp, one bit per digit.
REQ-010 frame_valid  output  1  one-cycle pulse when a complete frame is published.
REQ-011 pat_err  output  1  one-cycle pulse when an unrecognised segment pattern is captured.
REQ-012 seq_err  output  1  one-cycle pulse on an out-of-order or illegal strobe.
REQ-013 err_digit  output  2  index of the digit that caused the last pat_err or seq_err; held until the next error.

Function
REQ-014 Pattern map SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000, blank=1111111->4'hF; every other pattern is invalid.
REQ-015 Stability counter SHALL reset to 0 whenever an or seg differs from its previous-cycle value; a capture occurs when the count reaches STABLE_CYCLES-1 while the same strobe is still held.
REQ-016 Each strobe period SHALL yield at most one capture; a further capture requires an to change first.
REQ-017 an=4'b1111 (blanking) SHALL be legal between digits and SHALL NOT advance or abort the frame.
REQ-018 An an value with more than one bit low SHALL raise seq_err, set err_digit to the expected index, and return to SYNC.
REQ-019 FSM states SHALL be SYNC, DIG0, DIG1, DIG2, DIG3.
REQ-020 SYNC waits for a stable capture on an=1110, stores it as digit 0, and moves to DIG1.
REQ-021 DIGk (k=1..3) SHALL accept a capture only on strobe k; a stable capture on any other single strobe raises seq_err and forces SYNC.
REQ-022 A capture on 1110 while in DIGk SHALL raise seq_err and restart the frame as a DIG0 capture, continuing to DIG1.
REQ-023 An invalid pattern SHALL raise pat_err, set err_digit=k, abort the frame, and go to SYNC.
REQ-024 After the digit-3 capture, digits and dp_flags SHALL update together with a frame_valid pulse on the next edge; the FSM returns to SYNC.
REQ-025 digits and dp_flags SHALL hold their values between frames; partial frames SHALL never be published.
REQ-026 Latency SHALL be exactly 1 cycle from the capture cycle of digit 3 to frame_valid.
REQ-027 If pat_err and seq_err conditions occur in the same cycle, only seq_err SHALL be asserted.

Reset
REQ-028 Asserting rst SHALL force SYNC, clear the counter and the partial frame, and set digits=16'hFFFF, dp_flags=0, frame_valid=0, pat_err=0, seq_err=0, err_digit=0.
REQ-029 A reset asserted mid-frame SHALL discard the partial frame; the first frame_valid after reset requires a full 0..3 sequence.

Structure
REQ-030 Package seg7_pkg SHALL hold the ten digit pattern constants, SEG_BLANK, BLANK_CODE=4'hF, and the FSM state type.
REQ-031 Combinational sub-module seg7_to_bcd (seg in -> code[3:0], valid out) SHALL perform the pattern lookup.

Verification
REQ-032 Scan 1,2,3,4 on strobes 0..3 with 6 cycles per strobe and 2 blank cycles between -> one frame_valid, digits=16'h4321.
REQ-033 Digit-1 pattern 1111111 with dp=1 -> digits[7:4]=4'hF, dp_flags[1]=1, no pat_err.
REQ-034 Digit-2 pattern 0101010 -> pat_err pulse, err_digit=2, no frame_valid, digits unchanged.
REQ-035 Strobe order 0,2 -> seq_err, err_digit=1, and the next clean frame is accepted.
REQ-036 seg glitching every 3 cycles with STABLE_CYCLES=4 -> no capture, no pulses.
REQ-037 rst asserted during DIG2 -> digits=16'hFFFF immediately; the following complete frame publishes correctly.
